// File: rtl/aes_pkg.sv
// Shared AES constants, mode/FSM encodings and the xtime helper
// used by the MixColumns engine and its GF(2^8) multipliers.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic {
    MODE_FWD = 1'b0,
    MODE_INV = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Rotation-0 coefficient row; coefficient j sits at bits [8j +: 8].
  localparam logic [31:0] FWD_COEF = 32'h01010302;
  localparam logic [31:0] INV_COEF = 32'h090D0B0E;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/gf_mul8.sv
// Combinational GF(2^8) multiplier: accumulates xtime powers of a_i
// selected by the bits of the runtime operand b_i.
module gf_mul8
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o
);

  always_comb begin
    logic [7:0] pow_d;
    p_o   = 8'h00;
    pow_d = a_i;
    for (int i = 0; i < 8; i++) begin
      if (b_i[i]) p_o = p_o ^ pow_d;
      pow_d = xtime(pow_d);
    end
  end

endmodule

// File: rtl/mix_column_engine.sv
// Iterative (Inv)MixColumns engine: one column datapath reused across NCOL
// columns, one column per cycle, with a valid/ready handshake on both sides.
module mix_column_engine
  import aes_pkg::*;
#(
  parameter int NCOL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [32*NCOL-1:0] state_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NCOL-1:0] state_out
);

  localparam int CW    = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int NSLOT = 1 << CW;

  generate
    if (NCOL < 1 || NCOL > 8) begin : g_ncol_check
      $error("mix_column_engine: NCOL must be in 1..8");
    end
  endgenerate

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  mode_e               mode_q;
  logic [32*NCOL-1:0]  in_q;
  logic [32*NCOL-1:0]  res_q;

  logic [31:0] col_slot [NSLOT];
  logic [31:0] col_d;
  logic [31:0] coef_d;
  logic [31:0] mix_d;
  logic [7:0]  prod [4][4];

  genvar gi, gk;

  // Padding slots keep the column mux index exactly CW bits wide.
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < NCOL) begin : g_used
        assign col_slot[gi] = in_q[32*gi +: 32];
      end else begin : g_pad
        assign col_slot[gi] = 32'h0;
      end
    end
  endgenerate

  assign col_d  = col_slot[cnt_q];
  assign coef_d = (mode_q == MODE_INV) ? INV_COEF : FWD_COEF;

  // Row r, input byte k uses coefficient (k - r) mod 4 of the rotation-0 row.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      for (gk = 0; gk < 4; gk++) begin : g_term
        gf_mul8 u_mul (
          .a_i (col_d[8*gk +: 8]),
          .b_i (coef_d[8*((gk - gi + 4) % 4) +: 8]),
          .p_o (prod[gi][gk])
        );
      end
      assign mix_d[8*gi +: 8] = prod[gi][0] ^ prod[gi][1] ^ prod[gi][2] ^ prod[gi][3];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_FWD;
      in_q    <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            in_q    <= state_in;
            mode_q  <= mode_e'(mode);
            cnt_q   <= '0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          for (int c = 0; c < NCOL; c++) begin
            if (cnt_q == CW'(c)) res_q[32*c +: 32] <= mix_d;
          end
          if (cnt_q == CW'(NCOL - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign state_out = res_q;

endmodule

// File: tb/tb_mix_column_engine.sv
// Self-checking bench: three engines (NCOL = 1, 4, 8) driven by directed
// and random transactions, compared against a matrix-level GF(2^8) model.
module tb_mix_column_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic [255:0] state_in;
  logic [2:0]   in_valid_v;
  logic [2:0]   out_ready_v;
  logic [2:0]   in_ready_v;
  logic [2:0]   out_valid_v;
  logic [31:0]  so1;
  logic [127:0] so4;
  logic [255:0] so8;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mix_column_engine #(.NCOL(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .mode(mode), .state_in(state_in[31:0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .state_out(so1)
  );

  mix_column_engine #(.NCOL(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .mode(mode), .state_in(state_in[127:0]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .state_out(so4)
  );

  mix_column_engine #(.NCOL(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .mode(mode), .state_in(state_in), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .state_out(so8)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] ref_col(input logic m, input logic [31:0] col);
    logic [7:0]  coef [4];
    logic [31:0] r;
    logic [7:0]  acc;
    if (m) coef = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    else   coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = 32'h0;
    for (int row = 0; row < 4; row++) begin
      acc = 8'h00;
      for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - row + 4) % 4], col[8*k +: 8]);
      r[8*row +: 8] = acc;
    end
    return r;
  endfunction

  function automatic int ncol_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 8);
  endfunction

  function automatic logic [255:0] ref_state(input logic m, input logic [255:0] data, input int n);
    logic [255:0] r;
    r = '0;
    for (int c = 0; c < n; c++) r[32*c +: 32] = ref_col(m, data[32*c +: 32]);
    return r;
  endfunction

  function automatic logic [255:0] rand256(input int n);
    logic [255:0] r;
    r = '0;
    for (int c = 0; c < n; c++) r[32*c +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [255:0] get_out(input int d);
    case (d)
      0:       return {224'b0, so1};
      1:       return {128'b0, so4};
      default: return so8;
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run_txn(input int d, input logic m, input logic [255:0] data,
                         output logic [255:0] res);
    int guard;
    int lat;
    guard = 0;
    while (in_ready_v[d] !== 1'b1 && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    check("ready_before_accept", 256'(in_ready_v[d]), 256'd1);
    mode          = m;
    state_in      = data;
    in_valid_v[d] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[d] = 1'b0;
    mode          = ~m;
    state_in      = rand256(8);
    lat = 0;
    while (out_valid_v[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 256'(lat), 256'(ncol_of(d)));
    res = get_out(d);
    out_ready_v[d] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[d] = 1'b0;
    check("release_ready_valid", {254'b0, in_ready_v[d], out_valid_v[d]}, 256'b10);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] data;
    logic [255:0] res;
    logic [255:0] back;
    logic [255:0] snap;
    logic         m;

    rst         = 1'b1;
    mode        = 1'b0;
    state_in    = '0;
    in_valid_v  = 3'b000;
    out_ready_v = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 256'(in_ready_v), 256'(3'b111));
    check("reset_out_valid", 256'(out_valid_v), 256'd0);
    check("reset_state_out8", so8, 256'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer vectors on the 4-column engine
    data = rand256(4);
    data[31:0] = 32'h455313DB;
    run_txn(1, 1'b0, data, res);
    check("kat_fwd_455313DB", 256'(res[31:0]), 256'(32'hBCA14D8E));
    check("kat_fwd_full", res, ref_state(1'b0, data, 4));

    data = rand256(4);
    data[31:0]  = 32'hBCA14D8E;
    data[63:32] = 32'h9D58DC9F;
    run_txn(1, 1'b1, data, res);
    check("kat_inv_BCA14D8E", 256'(res[31:0]), 256'(32'h455313DB));
    check("kat_inv_9D58DC9F", 256'(res[63:32]), 256'(32'h5C220AF2));
    check("kat_inv_full", res, ref_state(1'b1, data, 4));

    data = rand256(4);
    data[95:64] = 32'h5C220AF2;
    run_txn(1, 1'b0, data, res);
    check("kat_fwd_5C220AF2", 256'(res[95:64]), 256'(32'h9D58DC9F));

    // Fixed points on the 8-column engine
    data = {8{32'hC6C6C6C6}};
    run_txn(2, 1'b0, data, res);
    check("c6_fwd", res, data);
    run_txn(2, 1'b1, data, res);
    check("c6_inv", res, data);
    run_txn(2, 1'b0, 256'd0, res);
    check("zero_fwd", res, 256'd0);
    run_txn(2, 1'b1, 256'd0, res);
    check("zero_inv", res, 256'd0);

    // Backpressure in DONE with an ignored in_valid pulse
    data = rand256(4);
    mode = 1'b1; state_in = data; in_valid_v[1] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[1] = 1'b0;
    for (int i = 0; i < 40 && out_valid_v[1] !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    snap = {128'b0, so4};
    check("bp_result", snap, ref_state(1'b1, data, 4));
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid_v[1] = 1'b1; mode = 1'b0; state_in = rand256(4);
      end
      @(posedge clk); #1;
      in_valid_v[1] = 1'b0;
      check("bp_stable", {128'b0, so4}, snap);
      check("bp_hold_flags", {254'b0, in_ready_v[1], out_valid_v[1]}, 256'b01);
    end
    out_ready_v[1] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[1] = 1'b0;
    check("bp_release", {254'b0, in_ready_v[1], out_valid_v[1]}, 256'b10);
    @(posedge clk); #1;
    check("bp_pulse_ignored", {254'b0, in_ready_v[1], out_valid_v[1]}, 256'b10);

    // Reset during the second BUSY cycle
    mode = 1'b0; state_in = rand256(4); in_valid_v[1] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_flags", {254'b0, in_ready_v[1], out_valid_v[1]}, 256'b10);
    check("midrst_state_out", {128'b0, so4}, 256'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midrst_no_output", 256'(out_valid_v[1]), 256'd0);
    end
    data = rand256(4);
    run_txn(1, 1'b1, data, res);
    check("midrst_recover", res, ref_state(1'b1, data, 4));

    // Random back-to-back sweep with round trip on every engine
    for (int d = 0; d < 3; d++) begin
      for (int it = 0; it < 8; it++) begin
        data = rand256(ncol_of(d));
        m    = 1'($urandom_range(0, 1));
        run_txn(d, m, data, res);
        check("rand_result", res, ref_state(m, data, ncol_of(d)));
        run_txn(d, ~m, res, back);
        check("rand_roundtrip", back, data);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
